aes_top: RTL and testbench



---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_top.sv | 93 +++++++++
 tb/tb_aes_top.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the iterative encryption block.
package aes_pkg;

  localparam logic [127:0] DEFAULT_PLAINTEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DEFAULT_KEY       = 128'h000102030405060708090a0b0c0d0e0f;

  // Index 0 is the constant used when deriving round key 1.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // Column bytes a0..a3 run from the MS byte down.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) multiplicative inverse followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // x^254 = x^-1 (and maps 0 to 0) via repeated squaring.
  always_comb begin
    w_sq  = i_byte;
    w_inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_top.sv
// AES-128 demo: encrypts a fixed block after reset at one round per clock, then
// holds the ciphertext and exposes a selectable 16-bit slice.
module aes_top
  import aes_pkg::*;
#(
  parameter logic [127:0] PLAINTEXT = DEFAULT_PLAINTEXT,
  parameter logic [127:0] KEY       = DEFAULT_KEY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  sel,
  output logic [15:0] out,
  output logic        done
);

  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_done;

  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;
  logic [127:0] w_next_key;
  logic [31:0]  w_rot;
  logic [31:0]  w_subword;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;

  for (genvar g = 0; g < 16; g++) begin : g_subbytes
    aes_sbox u_sbox (.i_byte(r_state[127-8*g -: 8]), .o_byte(w_sub[127-8*g -: 8]));
  end

  assign w_rot = {r_key[23:0], r_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.i_byte(w_rot[31-8*g -: 8]), .o_byte(w_subword[31-8*g -: 8]));
  end

  // Byte (row r, column c) lives at index 4c+r; row r rotates left by r columns.
  always_comb begin
    w_shift = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_shift[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    w_mix = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = mix_column(w_shift[127-32*c -: 32]);
    end
  end

  assign w_k0       = r_key[127:96] ^ w_subword ^ {rcon(r_round), 24'h0};
  assign w_k1       = r_key[95:64] ^ w_k0;
  assign w_k2       = r_key[63:32] ^ w_k1;
  assign w_k3       = r_key[31:0]  ^ w_k2;
  assign w_next_key = {w_k0, w_k1, w_k2, w_k3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PLAINTEXT;
      r_key   <= KEY;
      r_round <= '0;
      r_done  <= 1'b0;
    end else if (!r_done) begin
      r_round <= r_round + 4'd1;
      if (r_round != 4'd10) r_key <= w_next_key;
      if (r_round == 4'd0) begin
        r_state <= r_state ^ r_key;
      end else if (r_round == 4'd10) begin
        r_state <= w_shift ^ r_key;
        r_done  <= 1'b1;
      end else begin
        r_state <= w_mix ^ r_key;
      end
    end
  end

  always_comb begin
    out = '0;
    if (r_done) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (sel == 3'(i)) out = r_state[127-16*i -: 16];
      end
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: FIPS-197 vectors with default and overridden parameters.
`timescale 1ns/1ps
module tb_aes_top;

  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] out_a, out_b;
  logic        done_a, done_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  aes_top u_dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel), .out(out_a), .done(done_a)
  );

  aes_top #(
    .PLAINTEXT(128'h3243f6a8885a308d313198a2e0370734),
    .KEY(128'h2b7e151628aed2a6abf7158809cf4f3c)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sel(sel), .out(out_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_expected();
    logic [127:0] ca, cb;
    ca = CT_A;
    cb = CT_B;
    for (int i = 0; i < 8; i++) begin
      q_a.push_back(ca[127-16*i -: 16]);
      q_b.push_back(cb[127-16*i -: 16]);
    end
  endtask

  // Release reset mid-cycle and follow the 11-edge latency edge by edge.
  task automatic release_and_check_latency();
    @(negedge clk);
    rst_n = 1'b1;
    push_expected();
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      if (c < 11) begin
        check("busy_done_a", 128'(done_a), 128'(0));
        check("busy_done_b", 128'(done_b), 128'(0));
      end else begin
        check("edge11_done_a", 128'(done_a), 128'(1));
        check("edge11_done_b", 128'(done_b), 128'(1));
      end
      if (c == 10) begin
        for (int s = 0; s < 8; s++) begin
          sel = 3'(s);
          #1;
          check("busy_out_a", 128'(out_a), 128'(0));
          check("busy_out_b", 128'(out_b), 128'(0));
        end
        sel = 3'd0;
      end
    end
  endtask

  task automatic drain_scoreboard();
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #50;
      if (q_a.size() == 0 || q_b.size() == 0) begin
        check("sb_underflow", 128'(1), 128'(0));
      end else begin
        check("slice_a", 128'(out_a), 128'(q_a.pop_front()));
        check("slice_b", 128'(out_b), 128'(q_b.pop_front()));
      end
    end
    check("sb_empty", 128'(q_a.size() + q_b.size()), 128'(0));
  endtask

  initial begin
    logic [127:0] ca;
    ca = CT_A;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 128'(done_a), 128'(0));
    check("reset_out", 128'(out_a), 128'(0));

    release_and_check_latency();
    drain_scoreboard();

    // Abort at cycle 5, then a full fresh run.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_done", 128'(done_a), 128'(0));
    check("abort_out", 128'(out_a), 128'(0));
    release_and_check_latency();
    drain_scoreboard();

    // Asynchronous clear of a finished result, no clock edge in between.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_done", 128'(done_a), 128'(0));
    check("async_clr_out", 128'(out_a), 128'(0));
    release_and_check_latency();
    drain_scoreboard();

    // Long hold: no re-encryption, done stays high.
    for (int c = 0; c < 100; c++) begin
      sel = 3'(c % 8);
      @(posedge clk);
      #1;
      check("hold_done", 128'(done_a), 128'(1));
      check("hold_out", 128'(out_a), 128'(ca[127-16*(c%8) -: 16]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
